// File: rtl/led_seq_pkg.sv
// Shared types for the LED result sequencer: FSM states, result word and
// the helper that selects one half of a result for the LEDs.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHOW_A = 2'd2,
    SHOW_B = 2'd3
  } state_t;

  typedef logic [31:0] result_t;

  localparam int LED_W = 16;

  function automatic logic [LED_W-1:0] pick_half(input result_t value, input logic upper);
    logic [LED_W-1:0] half;
    if (upper) begin
      half = value[31:16];
    end else begin
      half = value[15:0];
    end
    return half;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO; only pointers and count are reset, storage is not.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module result_fifo
  import led_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_btn,
  input  logic                       push,
  input  logic                       pop,
  input  result_t                    push_data,
  output result_t                    head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  result_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data storage write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/led_result_sequencer.sv
// Queues processor results and paces them onto the LEDs, holding each one for
// HOLD_CYCLES per displayed half, optionally alternating lower then upper half.
module led_result_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                       clk,
  input  logic                       reset_btn,
  input  logic [31:0]                result_in,
  input  logic                       result_valid,
  input  logic [1:0]                 sw,
  output logic [15:0]                led,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       busy
);

  // A one-cycle hold still needs a one-bit counter
  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'sd1);

  state_t            state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  result_t           display_reg;
  logic              overflow_r;
  logic              pop_s;
  logic              hold_done_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  result_t           fifo_head_s;

  assign pop_s       = (state_r == LOAD);
  assign hold_done_s = (hold_cnt_r == HOLD_LAST);
  assign busy        = (state_r != IDLE);
  assign overflow    = overflow_r;

  result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_btn (reset_btn),
    .push      (result_valid),
    .pop       (pop_s),
    .push_data (result_in),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count)
  );

  // Sequencing FSM, hold counter and display register
  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      state_r     <= IDLE;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      display_reg <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          display_reg <= fifo_head_s;
          hold_cnt_r  <= {HOLD_W{1'b0}};
          state_r     <= SHOW_A;
        end
        SHOW_A: begin
          if (hold_done_s) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            state_r    <= sw[1] ? SHOW_B : IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
          end
        end
        SHOW_B: begin
          if (hold_done_s) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            state_r    <= IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1'b1);
          end
        end
        default: begin
          hold_cnt_r <= {HOLD_W{1'b0}};
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Sticky flag for a push dropped against a full FIFO
  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      overflow_r <= 1'b0;
    end else if (result_valid && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // LED half selection; auto mode follows the live sw[1]
  always_comb begin
    led = pick_half(display_reg, sw[0]);
    case (state_r)
      SHOW_A: begin
        if (sw[1]) begin
          led = pick_half(display_reg, 1'b0);
        end else begin
          led = pick_half(display_reg, sw[0]);
        end
      end
      SHOW_B:  led = pick_half(display_reg, 1'b1);
      default: led = pick_half(display_reg, sw[0]);
    endcase
  end

endmodule

// File: tb/tb_led_result_sequencer.sv
// Scoreboard bench for led_result_sequencer with DEPTH=4, HOLD_CYCLES=4.
`timescale 1ns/1ps
module tb_led_result_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        clk          = 1'b0;
  logic        reset_btn    = 1'b1;
  logic [31:0] result_in    = 32'h0000_0000;
  logic        result_valid = 1'b0;
  logic [1:0]  sw           = 2'b00;
  logic [15:0] led;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          obs_cyc_q [$];
  logic        busy_d1 = 1'b0;
  logic        busy_d2 = 1'b0;

  led_result_sequencer #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .reset_btn    (reset_btn),
    .result_in    (result_in),
    .result_valid (result_valid),
    .sw           (sw),
    .led          (led),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Capture the LEDs on the first SHOW_A cycle of every result (busy pattern 0,1,1)
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset_btn) begin
      busy_d1 = 1'b0;
      busy_d2 = 1'b0;
    end else begin
      if (!busy_d2 && busy_d1 && busy) begin
        obs_q.push_back(led);
        obs_cyc_q.push_back(cyc);
      end
      busy_d2 = busy_d1;
      busy_d1 = busy;
    end
  end

  task automatic test_reset();
    reset_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_btn = 1'b0;
    @(negedge clk);
    checks++; if (led !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h want 0000", led); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_manual();
    logic [31:0] e;
    logic [15:0] o;
    sw = 2'b00;
    result_in = 32'hDEAD_BEEF; result_valid = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1 result_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL manual_count_push: got %0d want 1", fifo_count); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL manual_load_busy: got %b want 1", busy); end
    checks++; if (led !== 16'h0000) begin errors++; $display("FAIL manual_load_led: got %h want 0000", led); end
    @(negedge clk);
    checks++; if (led !== 16'hBEEF) begin errors++; $display("FAIL manual_show_led: got %h want beef", led); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL manual_count_pop: got %0d want 0", fifo_count); end
    for (int i = 0; i < HOLD - 1; i++) begin
      @(negedge clk);
      checks++; if (led !== 16'hBEEF || busy !== 1'b1) begin errors++; $display("FAIL manual_hold_%0d: got led=%h busy=%b want beef/1", i, led, busy); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || led !== 16'hBEEF) begin errors++; $display("FAIL manual_idle: got led=%h busy=%b want beef/0", led, busy); end
    sw = 2'b01;
    #1;
    checks++; if (led !== 16'hDEAD) begin errors++; $display("FAIL manual_upper: got %h want dead", led); end
    repeat (3) @(negedge clk);
    checks++; if (led !== 16'hDEAD || busy !== 1'b0) begin errors++; $display("FAIL manual_retain: got led=%h busy=%b want dead/0", led, busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL manual_shown: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL manual_missing: got none want %h", e[15:0]); end
      else begin
        o = obs_q.pop_front();
        if (o !== e[15:0]) begin errors++; $display("FAIL manual_order: got %h want %h", o, e[15:0]); end
      end
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_auto();
    sw = 2'b10;
    #1;
    checks++; if (led !== 16'hBEEF) begin errors++; $display("FAIL auto_idle_mux: got %h want beef", led); end
    result_in = 32'h1234_5678; result_valid = 1'b1;
    @(posedge clk); #1 result_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (led !== 16'hBEEF || busy !== 1'b1) begin errors++; $display("FAIL auto_load: got led=%h busy=%b want beef/1", led, busy); end
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      checks++; if (led !== 16'h5678) begin errors++; $display("FAIL auto_lower_%0d: got %h want 5678", i, led); end
    end
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      checks++; if (led !== 16'h1234 || busy !== 1'b1) begin errors++; $display("FAIL auto_upper_%0d: got led=%h busy=%b want 1234/1", i, led, busy); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || led !== 16'h5678) begin errors++; $display("FAIL auto_idle: got led=%h busy=%b want 5678/0", led, busy); end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_burst();
    int n;
    int prev;
    int c;
    logic [31:0] e;
    logic [15:0] o;
    sw = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      result_in = 32'h0000_0000 + i; result_valid = 1'b1; exp_q.push_back(32'h0000_0000 + i);
      @(posedge clk); #1;
      if (i == 1) begin
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL burst_count_1: got %0d want 1", fifo_count); end
      end else begin
        // the third push lands on the LOAD edge that pops 0x1, so occupancy stays at 2
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL burst_count_%0d: got %0d want 2", i, fifo_count); end
      end
    end
    result_valid = 1'b0;
    n = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL burst_drain_timeout: busy=%b count=%0d", busy, fifo_count); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_shown: got %0d want %0d", obs_q.size(), exp_q.size()); end
    prev = -1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL burst_missing: got none want %h", e[15:0]); end
      else begin
        o = obs_q.pop_front();
        c = obs_cyc_q.pop_front();
        if (o !== e[15:0]) begin errors++; $display("FAIL burst_order: got %h want %h", o, e[15:0]); end
        if (prev >= 0) begin
          checks++; if (c - prev != HOLD + 2) begin errors++; $display("FAIL burst_period: got %0d want %0d", c - prev, HOLD + 2); end
        end
        prev = c;
      end
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_overflow();
    int n;
    logic [31:0] e;
    logic [15:0] o;
    sw = 2'b00;
    result_in = 32'hA0A0_00A0; result_valid = 1'b1; exp_q.push_back(32'hA0A0_00A0);
    @(posedge clk); #1 result_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 1; i <= 5; i++) begin
      result_in = 32'hB0B0_00B0 + i; result_valid = 1'b1;
      if (i < 5) exp_q.push_back(32'hB0B0_00B0 + i);
      @(posedge clk); #1;
      if (i == 4) begin
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: got count=%0d ovf=%b want 4/0", fifo_count, overflow); end
      end
    end
    result_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    n = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL ovf_drain_timeout: busy=%b count=%0d", busy, fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_shown: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL ovf_missing: got none want %h", e[15:0]); end
      else begin
        o = obs_q.pop_front();
        if (o !== e[15:0]) begin errors++; $display("FAIL ovf_order: got %h want %h", o, e[15:0]); end
      end
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_full_pop();
    int n;
    logic [31:0] e;
    logic [15:0] o;
    reset_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_btn = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_clear: got %b want 0", overflow); end
    sw = 2'b00;
    result_in = 32'hC0C0_00C0; result_valid = 1'b1; exp_q.push_back(32'hC0C0_00C0);
    @(posedge clk); #1 result_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 1; i <= 4; i++) begin
      result_in = 32'hF0F0_00F0 + i; result_valid = 1'b1; exp_q.push_back(32'hF0F0_00F0 + i);
      @(posedge clk); #1;
    end
    result_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got %0d want 4", fifo_count); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_load: got busy=%b count=%0d want 1/4", busy, fifo_count); end
    result_in = 32'hF0F0_00F5; result_valid = 1'b1; exp_q.push_back(32'hF0F0_00F5);
    @(posedge clk); #1 result_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    n = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 300) begin @(negedge clk); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL fullpop_drain_timeout: busy=%b count=%0d", busy, fifo_count); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fullpop_shown: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL fullpop_missing: got none want %h", e[15:0]); end
      else begin
        o = obs_q.pop_front();
        if (o !== e[15:0]) begin errors++; $display("FAIL fullpop_order: got %h want %h", o, e[15:0]); end
      end
    end
    obs_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_reset_mid_show();
    sw = 2'b00;
    result_in = 32'h5555_1111; result_valid = 1'b1;
    @(posedge clk); #1 result_in = 32'h6666_2222;
    @(posedge clk); #1 result_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (led !== 16'h1111 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got led=%h busy=%b want 1111/1", led, busy); end
    #2 reset_btn = 1'b1;
    #1;
    checks++; if (led !== 16'h0000) begin errors++; $display("FAIL midrst_led: got %h want 0000", led); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
    repeat (2) @(posedge clk);
    #1 reset_btn = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0 || fifo_count !== 3'd0 || led !== 16'h0000) begin errors++; $display("FAIL midrst_discard: got busy=%b count=%0d led=%h want 0/0/0000", busy, fifo_count, led); end
    exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_burst();
    test_overflow();
    test_full_pop();
    test_reset_mid_show();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
